// File: rtl/sort_stream_ctrl.sv
// Stream wrapper around the insertion_sort block: loads a batch with push commands,
// sorts it, then drains it with pop commands onto a valid/ready output stream.
module sort_stream_ctrl #(
    parameter int unsigned DW    = 16,
    parameter int unsigned DEPTH = 255,
    parameter int unsigned TMO   = 16
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          enable,
    input  logic [DW-1:0] s_data,
    input  logic          s_valid,
    input  logic          s_last,
    output logic          s_ready,
    output logic [DW-1:0] m_data,
    output logic          m_valid,
    output logic          m_last,
    input  logic          m_ready,
    output logic          srt_push,
    output logic          srt_pop,
    output logic          srt_clear,
    output logic          srt_sort,
    output logic [DW-1:0] srt_din,
    input  logic [DW-1:0] srt_dout,
    input  logic          srt_full,
    input  logic          srt_empty,
    input  logic          srt_idle,
    output logic          busy,
    output logic          err,
    output logic [8:0]    cnt
);

    typedef enum logic [2:0] {StIdle, StLoad, StSort, StPop, StEmit, StErr} state_e;

    localparam int unsigned TW       = $clog2(TMO + 1);
    localparam logic [8:0]  DepthCnt = 9'(DEPTH);
    localparam logic [TW-1:0] TmoLast = TW'(TMO - 1);

    state_e        state_q;
    logic          wait_q;     // a command is outstanding
    logic          phase_b_q;  // idle has dropped, waiting for it to rise again
    logic          last_q;
    logic [TW-1:0] tmo_q;

    // Gated by enable so a frozen block never completes an input handshake.
    assign s_ready = enable && (state_q == StLoad) && !wait_q && !srt_full && (cnt < DepthCnt);
    assign busy    = (state_q != StIdle);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= StIdle;
            wait_q    <= 1'b0;
            phase_b_q <= 1'b0;
            last_q    <= 1'b0;
            tmo_q     <= '0;
            srt_push  <= 1'b0;
            srt_pop   <= 1'b0;
            srt_clear <= 1'b0;
            srt_sort  <= 1'b0;
            srt_din   <= '0;
            m_data    <= '0;
            m_valid   <= 1'b0;
            m_last    <= 1'b0;
            err       <= 1'b0;
            cnt       <= '0;
        end else if (enable) begin
            if (wait_q) begin
                if (!phase_b_q) begin
                    if (!srt_idle) begin
                        phase_b_q <= 1'b1;
                    end else if (tmo_q == TmoLast) begin
                        state_q <= StErr;
                        err     <= 1'b1;
                        wait_q  <= 1'b0;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end else if (srt_idle) begin
                    wait_q <= 1'b0;
                    unique case (state_q)
                        StIdle: state_q <= StLoad;
                        StLoad: if (last_q || cnt == DepthCnt) state_q <= StSort;
                        StSort: state_q <= StPop;
                        StPop: begin
                            m_data  <= srt_dout;
                            m_last  <= srt_empty;
                            m_valid <= 1'b1;
                            state_q <= StEmit;
                        end
                        default: ;
                    endcase
                end
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (s_valid) begin
                            cnt       <= '0;
                            srt_clear <= ~srt_clear;
                            wait_q    <= 1'b1;
                            phase_b_q <= 1'b0;
                            tmo_q     <= '0;
                        end
                    end
                    StLoad: begin
                        if (s_ready && s_valid) begin
                            srt_din   <= s_data;
                            last_q    <= s_last;
                            cnt       <= cnt + 9'd1;
                            srt_push  <= ~srt_push;
                            wait_q    <= 1'b1;
                            phase_b_q <= 1'b0;
                            tmo_q     <= '0;
                        end
                    end
                    StSort: begin
                        if (cnt >= 9'd2) begin
                            srt_sort  <= ~srt_sort;
                            wait_q    <= 1'b1;
                            phase_b_q <= 1'b0;
                            tmo_q     <= '0;
                        end else begin
                            state_q <= StPop;
                        end
                    end
                    StPop: begin
                        if (srt_empty) begin
                            state_q <= StIdle;
                        end else begin
                            srt_pop   <= ~srt_pop;
                            wait_q    <= 1'b1;
                            phase_b_q <= 1'b0;
                            tmo_q     <= '0;
                        end
                    end
                    StEmit: begin
                        if (m_ready) begin
                            m_valid <= 1'b0;
                            state_q <= m_last ? StIdle : StPop;
                        end
                    end
                    StErr: ;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sort_stream_ctrl.sv
// Bench for sort_stream_ctrl with a behavioural toggle-command insertion sorter
// and a scoreboard of expected output words.
module tb_sort_stream_ctrl;

    localparam int TMO_C   = 16;
    localparam int DEPTH_C = 255;

    logic        clk = 1'b0;
    logic        rstn, enable;
    logic [15:0] s_data;
    logic        s_valid, s_last, s_ready;
    logic [15:0] m_data;
    logic        m_valid, m_last, m_ready;
    logic        srt_push, srt_pop, srt_clear, srt_sort;
    logic [15:0] srt_din, srt_dout;
    logic        srt_full, srt_empty, srt_idle;
    logic        busy, err;
    logic [8:0]  cnt;

    sort_stream_ctrl #(.DW(16), .DEPTH(DEPTH_C), .TMO(TMO_C)) dut (
        .clk(clk), .rstn(rstn), .enable(enable),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
        .srt_push(srt_push), .srt_pop(srt_pop), .srt_clear(srt_clear), .srt_sort(srt_sort),
        .srt_din(srt_din), .srt_dout(srt_dout),
        .srt_full(srt_full), .srt_empty(srt_empty), .srt_idle(srt_idle),
        .busy(busy), .err(err), .cnt(cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
        end
    endtask

    // ---------------- behavioural sorter ----------------
    typedef logic [15:0] arr_t [256];
    arr_t        mem;
    int          mdl_size;
    logic [3:0]  cs1, cs2, cs3, chg, op;  // {clear, push, sort, pop}
    int          busy_cnt;
    logic        stall_push;

    function automatic arr_t sort_asc(input arr_t a, input int n);
        arr_t r = a;
        logic [15:0] t;
        int j;
        for (int i = 1; i < n; i++) begin
            t = r[i];
            j = i - 1;
            while (j >= 0 && r[j] > t) begin
                r[j+1] = r[j];
                j--;
            end
            r[j+1] = t;
        end
        return r;
    endfunction

    assign srt_full  = (mdl_size == DEPTH_C);
    assign srt_empty = (mdl_size == 0);

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cs1 <= '0; cs2 <= '0; cs3 <= '0; op <= '0;
            busy_cnt <= 0; mdl_size <= 0; srt_idle <= 1'b1; srt_dout <= '0;
        end else begin
            cs1 <= {srt_clear, srt_push, srt_sort, srt_pop};
            cs2 <= cs1;
            cs3 <= cs2;
            if (busy_cnt > 0) begin
                if (busy_cnt == 1) begin
                    if (op[3]) mdl_size <= 0;
                    if (op[2]) begin mem[mdl_size] <= srt_din; mdl_size <= mdl_size + 1; end
                    if (op[1]) mem <= sort_asc(mem, mdl_size);
                    if (op[0]) begin srt_dout <= mem[mdl_size-1]; mdl_size <= mdl_size - 1; end
                    srt_idle <= 1'b1;
                end
                busy_cnt <= busy_cnt - 1;
            end else if (cs2 != cs3) begin
                chg = cs2 ^ cs3;
                if (!(chg[2] && stall_push)) begin
                    op       <= chg;
                    srt_idle <= 1'b0;
                    busy_cnt <= chg[1] ? 12 + mdl_size / 8 : 2;
                end
            end
        end
    end

    // ---------------- command toggle counters ----------------
    int n_clr = 0, n_psh = 0, n_srt = 0, n_pop = 0;
    logic [3:0] prv = '0;
    always begin
        @(posedge clk);
        #1;
        if (rstn) begin
            if (srt_clear != prv[3]) n_clr++;
            if (srt_push  != prv[2]) n_psh++;
            if (srt_sort  != prv[1]) n_srt++;
            if (srt_pop   != prv[0]) n_pop++;
        end
        prv = {srt_clear, srt_push, srt_sort, srt_pop};
    end

    // ---------------- scoreboard ----------------
    logic [16:0] exp_q[$];
    logic [15:0] batch[$];
    int          out_n = 0;

    always @(negedge clk) begin
        logic [16:0] e;
        if (rstn && enable && m_valid && m_ready) begin
            check("out_unexpected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("out_word", 32'({m_last, m_data}), 32'(e));
            end
            out_n++;
        end
    end

    task automatic commit_batch();
        logic [15:0] b[$];
        logic l;
        b = batch;
        b.rsort();
        for (int i = 0; i < b.size(); i++) begin
            l = (i == b.size() - 1);
            exp_q.push_back({l, b[i]});
        end
        batch.delete();
    endtask

    task automatic send_word(input logic [15:0] d, input logic l);
        int n = 0;
        @(negedge clk);
        s_data = d; s_valid = 1'b1; s_last = l;
        while (!s_ready && n < 20000) begin @(negedge clk); n++; end
        check("send_timeout", 32'(n >= 20000), 0);
        @(posedge clk); #1;
        s_valid = 1'b0; s_last = 1'b0;
        batch.push_back(d);
        if (l) commit_batch();
    endtask

    task automatic drain(input string tag);
        int n = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || busy) && n < 20000) begin @(negedge clk); n++; end
        check(tag, 32'(n >= 20000), 0);
    endtask

    task automatic wait_mvalid(input string tag);
        int n = 0;
        @(negedge clk);
        while (!m_valid && n < 5000) begin @(negedge clk); n++; end
        check(tag, 32'(n >= 5000), 0);
    endtask

    task automatic check_reset_outs(input string tag);
        check(tag, 32'({s_ready, m_valid, m_last, m_data, srt_push, srt_pop, srt_clear,
                        srt_sort, err, busy}), 0);
        check({tag, "_din"}, 32'(srt_din), 0);
        check({tag, "_cnt"}, 32'(cnt), 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int c0, p0, s0, q0, o0, n;
        rstn = 1'b0; enable = 1'b1; s_data = '0; s_valid = 1'b0; s_last = 1'b0;
        m_ready = 1'b1; stall_push = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outs("reset");
        rstn = 1'b1;

        // Basic four-word batch
        send_word(16'h0030, 1'b0);
        send_word(16'h0010, 1'b0);
        send_word(16'h0040, 1'b0);
        send_word(16'h0020, 1'b1);
        drain("b1_drain");
        check("b1_clear", n_clr, 1);
        check("b1_push", n_psh, 4);
        check("b1_sort", n_srt, 1);
        check("b1_pop", n_pop, 4);
        check("b1_cnt", 32'(cnt), 4);

        // Single word: no sort
        c0 = n_clr; s0 = n_srt; q0 = n_pop;
        send_word(16'h1234, 1'b1);
        drain("b2_drain");
        check("b2_sort", n_srt - s0, 0);
        check("b2_pop", n_pop - q0, 1);
        check("b2_clear", n_clr - c0, 1);
        check("b2_busy", 32'(busy), 0);
        check("b2_cnt", 32'(cnt), 1);

        // Backpressure on the second output word
        @(posedge clk); #1 m_ready = 1'b0;
        send_word(16'h0005, 1'b0);
        send_word(16'h0009, 1'b0);
        send_word(16'h0001, 1'b1);
        wait_mvalid("b3_first");
        @(posedge clk); #1 m_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1 m_ready = 1'b0;
        wait_mvalid("b3_second");
        q0 = n_pop;
        repeat (20) begin
            @(negedge clk);
            check("hold_data", 32'(m_data), 32'h0005);
            check("hold_last", 32'(m_last), 0);
            check("hold_valid", 32'(m_valid), 1);
            check("hold_pop", n_pop - q0, 0);
        end
        @(posedge clk); #1 m_ready = 1'b1;
        drain("b3_drain");

        // 256 words without last: forced end at DEPTH, word 256 starts next batch
        for (int i = 0; i < 255; i++) send_word(16'((i * 97 + 13) % 65536), 1'b0);
        commit_batch();
        c0 = n_clr; o0 = out_n;
        send_word(16'hBEEF, 1'b0);
        check("full_outs", out_n - o0, 255);
        check("full_clear", n_clr - c0, 1);
        send_word(16'h0007, 1'b1);
        drain("full_drain");
        check("full_cnt2", 32'(cnt), 2);

        // Push never acknowledged: timeout to error
        stall_push = 1'b1;
        p0 = n_psh;
        send_word(16'hAAAA, 1'b0);
        batch.delete();
        n = 0;
        while (!err && n < 100) begin @(negedge clk); n++; end
        check("err_latency", n, TMO_C + 1);
        check("err_push", n_psh - p0, 1);
        check("err_s_ready", 32'(s_ready), 0);
        check("err_m_valid", 32'(m_valid), 0);
        repeat (5) @(negedge clk);
        check("err_sticky", 32'(err), 1);
        rstn = 1'b0;
        stall_push = 1'b0;
        @(negedge clk);
        check_reset_outs("err_reset");
        rstn = 1'b1;

        // Freeze mid-sort, then reset mid-pop
        s0 = n_srt;
        send_word(16'h0100, 1'b0);
        send_word(16'h0600, 1'b0);
        send_word(16'h0300, 1'b0);
        send_word(16'h0500, 1'b0);
        send_word(16'h0200, 1'b0);
        send_word(16'h0400, 1'b1);
        n = 0;
        while (n_srt == s0 && n < 1000) begin @(negedge clk); n++; end
        check("frz_sort_seen", 32'(n >= 1000), 0);
        n = 0;
        while (srt_idle && n < 100) begin @(negedge clk); n++; end
        check("frz_idle_low", 32'(n >= 100), 0);
        repeat (2) @(negedge clk);
        enable = 1'b0;
        s0 = n_srt; q0 = n_pop; c0 = n_clr;
        repeat (10) begin
            @(negedge clk);
            check("frz_busy", 32'(busy), 1);
            check("frz_m_valid", 32'(m_valid), 0);
            check("frz_s_ready", 32'(s_ready), 0);
            check("frz_cnt", 32'(cnt), 6);
            check("frz_cmds", (n_srt - s0) + (n_pop - q0) + (n_clr - c0), 0);
        end
        enable = 1'b1;
        o0 = out_n; q0 = n_pop;
        n = 0;
        while ((out_n == o0 || n_pop < q0 + 2) && n < 2000) begin @(negedge clk); n++; end
        check("rst_mid_pop", 32'(n >= 2000), 0);
        rstn = 1'b0;
        @(negedge clk);
        check_reset_outs("mid_reset");
        exp_q.delete();
        batch.delete();
        rstn = 1'b1;
        c0 = n_clr;
        send_word(16'h0003, 1'b0);
        send_word(16'h0001, 1'b0);
        send_word(16'h0002, 1'b1);
        drain("post_drain");
        check("post_clear", n_clr - c0, 1);
        check("post_cnt", 32'(cnt), 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sort_stream_ctrl.md
Name: sort_stream_ctrl

Overview:
Stream front-end/back-end for the insertion_sort block.
- Accepts a valid/ready input batch terminated by s_last and loads it into the sorter with push commands.
- Issues sort, then drains the sorter with pop commands, presenting each popped word on a valid/ready output stream with m_last on the final word.
- Drives the sorter's toggle-style command levels and monitors its idle/full/empty flags.

Parameters:
DW, 16, data width on both streams and sorter data ports
DEPTH, 255, max items per batch (sorter full point)
TMO, 16, max cycles from command toggle to sorter idle falling before error

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
enable  in  1  clock enable; when low all state and outputs hold
s_data  in  DW  input word
s_valid  in  1  input valid
s_last  in  1  last word of batch
s_ready  out  1  input accept
m_data  out  DW  output word
m_valid  out  1  output valid
m_last  out  1  final output word of batch
m_ready  in  1  output accept
srt_push, srt_pop, srt_clear, srt_sort  out  1 each  command levels; each transition is one command
srt_din  out  DW  sorter write data
srt_dout  in  DW  sorter read data
srt_full, srt_empty, srt_idle  in  1 each  sorter status
busy  out  1  state != S_IDLE
err  out  1  sticky handshake timeout
cnt  out  9  items accepted in current batch

Behaviour:
- Reset: all command levels 0, srt_din=0, m_data=0, m_valid=0, m_last=0, s_ready=0, err=0, cnt=0, state S_IDLE. Reset mid-batch abandons the batch; the next batch starts with clear.
- Command issue: invert one command level for one cycle, then enter wait.
  - Phase A: wait for srt_idle=0. If not seen within TMO cycles, go to S_ERR.
  - Phase B: wait for srt_idle=1; no timeout, because sort runtime is data-dependent.
  - Command is complete when phase B sees idle=1. Only one command is outstanding at a time.
- States:
  - S_IDLE: s_ready=0. On s_valid=1: cnt<=0, toggle srt_clear, wait, then go to S_LOAD. s_data is not consumed yet.
  - S_LOAD: s_ready=1 while no command is outstanding, srt_full=0 and cnt<DEPTH. On handshake:
    - srt_din<=s_data, latch s_last, cnt<=cnt+1, toggle srt_push, wait.
    - On completion: if latched last, or cnt==DEPTH (forced end; the next input word starts a new batch), go to S_SORT; otherwise stay in S_LOAD.
  - S_SORT: if cnt>=2, toggle srt_sort and wait, then go to S_POP; if cnt<2, go directly to S_POP.
  - S_POP: if srt_empty=1, go to S_IDLE. Otherwise toggle srt_pop and wait. On completion: m_data<=srt_dout, m_last<=srt_empty (sampled at completion), m_valid<=1, go to S_EMIT.
  - S_EMIT: hold m_data/m_last stable until m_ready=1. On handshake: m_valid<=0; if m_last, go to S_IDLE, else go to S_POP.
  - S_ERR: err=1, s_ready=0, m_valid=0, command levels frozen; exit only by reset.
- s_ready is asserted only in S_LOAD, never during a wait. m_valid is asserted only in S_EMIT.
- Output order is exactly the sorter's pop order; the block never reorders data.
- cnt saturates at DEPTH; the 9-bit width avoids wrap.
- enable=0 freezes state, the timeout counter and all outputs. TMO counting resumes on re-enable.

Test Plan:
- Reset, with the bench using a behavioural insertion_sort command model (2-stage toggle sync, pop returns top of ascending array) -> all outputs 0, busy=0. Then batch 0x0030,0x0010,0x0040,0x0020 with last on 4th -> m_data 0x0040,0x0030,0x0020,0x0010; m_last=1 only on 0x0010; cnt=4; exactly one clear, four push, one sort and four pop toggles.
- Single-word batch 0x1234 with last -> no sort toggle; one output 0x1234 with m_last=1; returns to S_IDLE.
- m_ready held low 20 cycles on second output word -> m_data/m_last stable for all 20 cycles, no pop toggle during hold; the sequence completes correctly afterwards.
- 256 words without last -> s_ready drops after 255 words; 255 outputs in descending order; the 256th word is consumed as the first word of the next batch, after a clear.
- Model never drops idle after push toggle -> err=1 exactly TMO cycles after the toggle, s_ready=0; only rstn clears err.
- enable low for 10 cycles mid-sort, then rstn pulse mid-pop -> no state change while enable is low; after reset all outputs 0 and the next batch begins with a clear toggle.
